// File: rtl/mw_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mw_stage_reg_pkg
// Purpose  : Shared pipeline definitions. This package holds the opcode and
//            func constants used by the stage controllers, the W-stage
//            write-data select encoding, and a load-opcode helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mw_stage_reg_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_LHU  = 6'b100101;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_SH   = 6'b101001;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // R-type func codes, instr[5:0]
  localparam logic [5:0] FUNC_JR   = 6'b001000;
  localparam logic [5:0] FUNC_JALR = 6'b001001;
  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;

  // Link offset: return address skips the branch delay slot
  localparam logic [31:0] LINK_OFFSET = 32'd8;

  // Register-file write-data source in W
  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_MEM  = 2'd1,
    WD_PC8  = 2'd2,
    WD_ZERO = 2'd3
  } wd_sel_e;

  function automatic logic is_load(input logic [5:0] opcode);
    return (opcode == OP_LW)  || (opcode == OP_LB)  || (opcode == OP_LBU) ||
           (opcode == OP_LH)  || (opcode == OP_LHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mw_stage_reg_w_dext.sv
`default_nettype none
// ============================================================================
// Module   : w_dext
// Purpose  : Combinational load-data extender for the W stage. It picks a
//            byte or halfword lane from the aligned memory word and then
//            sign- or zero-extends it. The lane mapping is little-endian.
// Ports    : opcode [5:0]  registered opcode of the W instruction
//            offset [1:0]  byte offset within the word (aluout[1:0])
//            word   [31:0] raw aligned word read from data memory
//            ext    [31:0] extended load data
// Revision : 1.0 - initial release
// ============================================================================
module w_dext
  import mw_stage_reg_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[7:0];
    case (offset)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
  end

  // Halfword lane chosen by offset[1] only; a misaligned offset[0] is ignored
  assign w_half = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    ext = word;
    case (opcode)
      OP_LW:   ext = word;
      OP_LB:   ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  ext = {24'd0, w_byte};
      OP_LH:   ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  ext = {16'd0, w_half};
      default: ext = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mw_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : mw_stage_reg
// Purpose  : M/W pipeline register with load-data extension, write-data
//            select and a retired-instruction counter. clr flushes a bubble
//            in and takes priority over en. en=0 stalls every register,
//            including the counter.
// Ports    : clk, reset                 clock, async active-high reset
//            en, clr                    latch enable (stall) / sync flush
//            M_instr/M_pc/M_aluout/M_dmrd   M-stage inputs
//            W_instr, W_pc8, W_aluout   registered instruction, pc+8, ALU
//            W_memdata, W_wd            extended load data, RF write data
//            W_retired                  non-bubble instruction count
// Revision : 1.0 - initial release
// ============================================================================
module mw_stage_reg
  import mw_stage_reg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] M_instr,
  input  logic [31:0] M_pc,
  input  logic [31:0] M_aluout,
  input  logic [31:0] M_dmrd,
  output logic [31:0] W_instr,
  output logic [31:0] W_pc8,
  output logic [31:0] W_aluout,
  output logic [31:0] W_memdata,
  output logic [31:0] W_wd,
  output logic [31:0] W_retired
);

  logic [31:0] instr_q,   instr_d;
  logic [31:0] pc_q,      pc_d;
  logic [31:0] aluout_q,  aluout_d;
  logic [31:0] dmrd_q,    dmrd_d;
  logic [31:0] retired_q, retired_d;

  // Next-state: flush beats enable; a flush holds the counter.
  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    aluout_d  = aluout_q;
    dmrd_d    = dmrd_q;
    retired_d = retired_q;
    if (clr) begin
      instr_d  = '0;
      pc_d     = '0;
      aluout_d = '0;
      dmrd_d   = '0;
    end else if (en) begin
      instr_d  = M_instr;
      pc_d     = M_pc;
      aluout_d = M_aluout;
      dmrd_d   = M_dmrd;
      if (M_instr != '0) begin
        retired_d = retired_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q   <= '0;
      pc_q      <= '0;
      aluout_q  <= '0;
      dmrd_q    <= '0;
      retired_q <= '0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      aluout_q  <= aluout_d;
      dmrd_q    <= dmrd_d;
      retired_q <= retired_d;
    end
  end

  logic [5:0]  w_opcode;
  logic [5:0]  w_func;
  logic [31:0] w_memdata;
  wd_sel_e     w_sel;

  assign w_opcode = instr_q[31:26];
  assign w_func   = instr_q[5:0];

  w_dext u_w_dext (
    .opcode (w_opcode),
    .offset (aluout_q[1:0]),
    .word   (dmrd_q),
    .ext    (w_memdata)
  );

  // An all-zero word (bubble or nop) must write zero even if the captured
  // aluout is nonzero, so it is checked ahead of the link/load selection.
  always_comb begin
    w_sel = WD_ALU;
    if (instr_q == '0) begin
      w_sel = WD_ZERO;
    end else if ((w_opcode == OP_JAL) ||
                 ((w_opcode == OP_R) && (w_func == FUNC_JALR))) begin
      w_sel = WD_PC8;
    end else if (is_load(w_opcode)) begin
      w_sel = WD_MEM;
    end
  end

  assign W_instr   = instr_q;
  assign W_pc8     = pc_q + LINK_OFFSET;
  assign W_aluout  = aluout_q;
  assign W_memdata = w_memdata;
  assign W_retired = retired_q;

  always_comb begin
    W_wd = aluout_q;
    case (w_sel)
      WD_ALU:  W_wd = aluout_q;
      WD_MEM:  W_wd = w_memdata;
      WD_PC8:  W_wd = W_pc8;
      default: W_wd = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mw_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mw_stage_reg
// Purpose  : Scoreboard testbench for mw_stage_reg. The stimulus process
//            pushes the expected W outputs for each clock edge. A monitor
//            process pops them and compares after each rising edge.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mw_stage_reg;

  localparam logic [5:0] T_LW = 6'b100011, T_LB = 6'b100000, T_LBU = 6'b100100;
  localparam logic [5:0] T_LH = 6'b100001, T_LHU = 6'b100101, T_JAL = 6'b000011;
  localparam logic [5:0] T_R = 6'b000000, T_JALR = 6'b001001, T_ADDU = 6'b100001;

  logic        clk = 1'b0;
  logic        reset, en, clr;
  logic [31:0] M_instr, M_pc, M_aluout, M_dmrd;
  logic [31:0] W_instr, W_pc8, W_aluout, W_memdata, W_wd, W_retired;

  typedef struct {
    logic [31:0] instr, pc8, alu, mem, wd, ret;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   stim_done = 1'b0;

  // Reference W-stage state, updated from the behavioural rules
  logic [31:0] m_instr = '0, m_pc = '0, m_alu = '0, m_dm = '0, m_ret = '0;

  always #5 clk = ~clk;

  mw_stage_reg dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clr       (clr),
    .M_instr   (M_instr),
    .M_pc      (M_pc),
    .M_aluout  (M_aluout),
    .M_dmrd    (M_dmrd),
    .W_instr   (W_instr),
    .W_pc8     (W_pc8),
    .W_aluout  (W_aluout),
    .W_memdata (W_memdata),
    .W_wd      (W_wd),
    .W_retired (W_retired)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [31:0] instr, input logic [31:0] alu,
                                            input logic [31:0] word);
    int unsigned off, b, h;
    logic [5:0]  op;
    op  = instr[31:26];
    off = alu % 4;
    b   = (word >> (8 * off)) % 256;
    h   = (word >> (16 * (off / 2))) % 65536;
    if (op == T_LB)  return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
    if (op == T_LBU) return 32'(b);
    if (op == T_LH)  return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
    if (op == T_LHU) return 32'(h);
    return word;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    logic [5:0] op;
    op = m_instr[31:26];
    e.instr = m_instr;
    e.pc8   = m_pc + 32'd8;
    e.alu   = m_alu;
    e.mem   = ext_model(m_instr, m_alu, m_dm);
    e.ret   = m_ret;
    if (m_instr == 32'd0)
      e.wd = 32'd0;
    else if (op == T_JAL || (op == T_R && m_instr[5:0] == T_JALR))
      e.wd = e.pc8;
    else if (op == T_LW || op == T_LB || op == T_LBU || op == T_LH || op == T_LHU)
      e.wd = e.mem;
    else
      e.wd = m_alu;
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge and push the expected
  // outputs for the following rising edge.
  task automatic step(input logic r, input logic e, input logic c, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] dm);
    @(negedge clk);
    reset = r; en = e; clr = c;
    M_instr = ins; M_pc = pc; M_aluout = alu; M_dmrd = dm;
    if (r) begin
      m_instr = '0; m_pc = '0; m_alu = '0; m_dm = '0; m_ret = '0;
    end else if (c) begin
      m_instr = '0; m_pc = '0; m_alu = '0; m_dm = '0;
    end else if (e) begin
      m_instr = ins; m_pc = pc; m_alu = alu; m_dm = dm;
      if (ins != 32'd0) m_ret = m_ret + 32'd1;
    end
    q.push_back(expect_now());
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned k;
    w = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: w[31:26] = T_LW;
      1: w[31:26] = T_LB;
      2: w[31:26] = T_LBU;
      3: w[31:26] = T_LH;
      4: w[31:26] = T_LHU;
      5: w[31:26] = T_JAL;
      6: begin w[31:26] = T_R; w[5:0] = T_JALR; end
      7: begin w[31:26] = T_R; w[5:0] = T_ADDU; end
      8: w = 32'd0;
      default: ;
    endcase
    return w;
  endfunction

  // Monitor: compare every rising edge for which an expectation exists
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("W_instr",   W_instr,   e.instr);
        cmp("W_pc8",     W_pc8,     e.pc8);
        cmp("W_aluout",  W_aluout,  e.alu);
        cmp("W_memdata", W_memdata, e.mem);
        cmp("W_wd",      W_wd,      e.wd);
        cmp("W_retired", W_retired, e.ret);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=stimulus_running required=stimulus_done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] addu;
    reset = 1'b1; en = 1'b0; clr = 1'b0;
    M_instr = '0; M_pc = '0; M_aluout = '0; M_dmrd = '0;
    addu = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, T_ADDU};

    // Reset for two edges, then release with en=0 and hold.
    step(1, 0, 0, 32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    step(1, 0, 0, 32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    step(0, 0, 0, 32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    step(0, 0, 0, 32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    after_edge();
    cmp("reset_pc8", W_pc8, 32'h8);
    cmp("reset_retired", W_retired, 32'd0);

    // Latch addu, stall three edges, then flush with en=0.
    step(0, 1, 0, addu, 32'h0000_0100, 32'h0000_0055, 32'h1111_2222);
    repeat (3) step(0, 0, 0, rand_instr(), $urandom, $urandom, $urandom);
    after_edge();
    cmp("stall_instr", W_instr, addu);
    cmp("stall_retired", W_retired, 32'd1);
    step(0, 0, 1, rand_instr(), $urandom, $urandom, $urandom);
    after_edge();
    cmp("flush_instr", W_instr, 32'd0);
    cmp("flush_wd", W_wd, 32'd0);
    cmp("flush_retired", W_retired, 32'd1);

    // Byte and halfword loads
    step(0, 1, 0, {T_LB, 26'h0A5_1234}, 32'h200, 32'h0000_1003, 32'h80FF_7F01);
    after_edge();
    cmp("lb_memdata", W_memdata, 32'hFFFF_FF80);
    cmp("lb_wd", W_wd, 32'hFFFF_FF80);
    step(0, 1, 0, {T_LBU, 26'h0A5_1234}, 32'h204, 32'h0000_1003, 32'h80FF_7F01);
    after_edge();
    cmp("lbu_wd", W_wd, 32'h0000_0080);
    step(0, 1, 0, {T_LH, 26'h011_2222}, 32'h208, 32'h0000_2002, 32'h9ABC_1234);
    after_edge();
    cmp("lh_wd", W_wd, 32'hFFFF_9ABC);
    step(0, 1, 0, {T_LHU, 26'h011_2222}, 32'h20C, 32'h0000_2003, 32'h9ABC_1234);
    after_edge();
    cmp("lhu_wd", W_wd, 32'h0000_9ABC);

    // Links
    step(0, 1, 0, {T_JAL, 26'h000_0C00}, 32'h0000_3000, 32'h7777_7777, 32'h0);
    after_edge();
    cmp("jal_wd", W_wd, 32'h0000_3008);
    step(0, 1, 0, {T_R, 5'd31, 5'd0, 5'd31, 5'd0, T_JALR}, 32'h0000_3000, 32'h7777_7777, 32'h0);
    after_edge();
    cmp("jalr_wd", W_wd, 32'h0000_3008);

    // Async reset arriving in the middle of a stall
    @(negedge clk);
    en = 1'b0; clr = 1'b0;
    #2 reset = 1'b1;
    #1;
    cmp("async_instr", W_instr, 32'd0);
    cmp("async_pc8", W_pc8, 32'h8);
    cmp("async_retired", W_retired, 32'd0);
    #1 reset = 1'b0;
    m_instr = '0; m_pc = '0; m_alu = '0; m_dm = '0; m_ret = '0;
    q.push_back(expect_now());
    step(0, 1, 0, {T_LW, 26'h1}, 32'h400, 32'h44, 32'h5A5A_A5A5);
    after_edge();
    cmp("post_reset_wd", W_wd, 32'h5A5A_A5A5);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
           rand_instr(), $urandom, $urandom, $urandom);
    end

    // Counter wrap: preset to max while stalled, then retire one instruction.
    @(negedge clk);
    en = 1'b0; clr = 1'b0;
    force dut.retired_q = 32'hFFFF_FFFF;
    m_ret = 32'hFFFF_FFFF;
    q.push_back(expect_now());
    #1 release dut.retired_q;
    step(0, 1, 0, addu, 32'h500, 32'h9, 32'h0);
    after_edge();
    cmp("wrap_retired", W_retired, 32'd0);

    @(posedge clk);
    #3;
    cmp("queue_drained", 32'(q.size()), 32'd0);
    stim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
